// File: rtl/lif_tdm_sched.sv
// Time-multiplexed leaky integrate-and-fire array: N virtual neurons share one update datapath.
// Latency: step at edge t updates neuron k at edge t+1+k; done pulses during the cycle after edge t+N.
// Backpressure: cur_ready low while sweeping; spikes queue in a pending mask, lost spikes/steps set overrun.
module lif_tdm_sched #(
    parameter int N_NEURONS = 4,
    parameter int THRESHOLD = 200,
    localparam int IW = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step,
    input  logic          cur_valid,
    input  logic [IW-1:0] cur_idx,
    input  logic [7:0]    cur_data,
    output logic          cur_ready,
    output logic          spike_valid,
    output logic [IW-1:0] spike_idx,
    input  logic          spike_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    input  logic [IW-1:0] mon_idx,
    output logic [7:0]    mon_state
);

    localparam logic [7:0]    THR  = 8'(THRESHOLD);
    localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [7:0]           current  [N_NEURONS];
    logic [7:0]           membrane [N_NEURONS];
    logic [N_NEURONS-1:0] spike_pending;

    logic                 upd_en;
    logic [7:0]           m_half;
    logic [8:0]           sum9;
    logic [7:0]           sum_sat;
    logic                 fire;
    logic [N_NEURONS-1:0] fire_mask;
    logic [N_NEURONS-1:0] consume_mask;
    logic                 spike_lost;
    logic                 step_drop;

    assign cur_ready   = (state == IDLE);
    assign spike_valid = |spike_pending;
    assign mon_state   = membrane[mon_idx];
    assign upd_en      = (state == RUN);
    assign step_drop   = step && (state != IDLE);

    // Shared update datapath: leak by halving, integrate current, saturate, compare to threshold.
    always_comb begin
        m_half  = membrane[idx] >> 1;
        sum9    = {1'b0, m_half} + {1'b0, current[idx]};
        sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
        fire    = (sum_sat >= THR);
    end

    // Lowest pending index is presented first; scan high-to-low so the lowest wins.
    always_comb begin
        spike_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (spike_pending[i]) begin
                spike_idx = IW'(i);
            end
        end
    end

    // Per-edge set/clear masks for the pending queue; a spike on an occupied, unconsumed bit is lost.
    always_comb begin
        consume_mask = '0;
        fire_mask    = '0;
        if (spike_valid && spike_ready) begin
            consume_mask = N_NEURONS'(1) << spike_idx;
        end
        if (upd_en && fire) begin
            fire_mask = N_NEURONS'(1) << idx;
        end
        spike_lost = |(fire_mask & spike_pending & ~consume_mask);
    end

    // Sweep sequencer with registered busy/done; steps arriving outside IDLE are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (step) begin
                        state <= RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == LAST) begin
                        state <= DONE;
                        idx   <= '0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Neuron state: current writes only land in IDLE, so a write alongside step feeds that sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                current[i]  <= '0;
                membrane[i] <= '0;
            end
        end else begin
            if (cur_valid && cur_ready) begin
                current[cur_idx] <= cur_data;
            end
            if (upd_en) begin
                membrane[idx] <= fire ? 8'd0 : sum_sat;
            end
        end
    end

    // Pending spike mask and sticky overrun; a new spike on a bit being consumed keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_pending <= '0;
            overrun       <= 1'b0;
        end else begin
            spike_pending <= (spike_pending & ~consume_mask) | fire_mask;
            if (spike_lost || step_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lif_tdm_sched.sv
module tb_lif_tdm_sched;

    localparam int N = 4;

    logic       clk;
    logic       reset_n;
    logic       step;
    logic       cur_valid;
    logic [1:0] cur_idx;
    logic [7:0] cur_data;
    logic       cur_ready;
    logic       spike_valid;
    logic [1:0] spike_idx;
    logic       spike_ready;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [1:0] mon_idx;
    logic [7:0] mon_state;

    int n_tests = 0;
    int n_fail  = 0;

    lif_tdm_sched #(.N_NEURONS(N), .THRESHOLD(200)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (step),
        .cur_valid  (cur_valid),
        .cur_idx    (cur_idx),
        .cur_data   (cur_data),
        .cur_ready  (cur_ready),
        .spike_valid(spike_valid),
        .spike_idx  (spike_idx),
        .spike_ready(spike_ready),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .mon_idx    (mon_idx),
        .mon_state  (mon_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_cur(input logic [1:0] i, input logic [7:0] v);
        cur_valid = 1'b1;
        cur_idx   = i;
        cur_data  = v;
        tick();
        cur_valid = 1'b0;
    endtask

    // Waits (bounded) for the done pulse of a sweep already launched, then returns to IDLE.
    task automatic finish_sweep();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 4 * N + 8; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("sweep_done", 32'(got), 32'd1);
        tick();
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        finish_sweep();
    endtask

    task automatic mon(input logic [1:0] i, input logic [7:0] exp, input string tag);
        mon_idx = i;
        #1;
        check(tag, 32'(mon_state), 32'(exp));
    endtask

    logic any_spike;

    initial begin
        step = 0; cur_valid = 0; cur_idx = 0; cur_data = 0;
        spike_ready = 0; mon_idx = 0; reset_n = 1;

        // Reset state
        do_reset();
        check("rst_spike_valid", 32'(spike_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cur_ready", 32'(cur_ready), 1);
        check("rst_overrun", 32'(overrun), 0);
        mon(0, 0, "rst_mon0");

        // current[0]=120: 120, 180, then spike
        write_cur(0, 120);
        do_step();
        mon(0, 120, "n0_step1");
        check("n0_nospike1", 32'(spike_valid), 0);
        do_step();
        mon(0, 180, "n0_step2");
        do_step();
        mon(0, 0, "n0_step3");
        check("n0_spike_valid", 32'(spike_valid), 1);
        check("n0_spike_idx", 32'(spike_idx), 0);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        check("n0_drained", 32'(spike_valid), 0);

        // current[1]=100 over 20 steps converges to 199 without firing
        write_cur(0, 0);
        write_cur(1, 100);
        any_spike = 1'b0;
        for (int s = 0; s < 20; s++) begin
            do_step();
            any_spike = any_spike | spike_valid;
        end
        check("n1_no_spike", 32'(any_spike), 0);
        mon(1, 199, "n1_converge");

        // current[2]=255 written together with step: saturating spike on first sweep
        write_cur(1, 0);
        cur_valid = 1'b1; cur_idx = 2; cur_data = 255; step = 1'b1;
        tick();
        cur_valid = 1'b0; step = 1'b0;
        finish_sweep();
        mon(2, 0, "n2_mem");
        check("n2_spike_valid", 32'(spike_valid), 1);
        check("n2_spike_idx", 32'(spike_idx), 2);
        check("n2_no_overrun", 32'(overrun), 0);

        // All neurons at 250 with consumer stalled: queue fills, second sweep overruns
        do_reset();
        for (int i = 0; i < N; i++) write_cur(2'(i), 250);
        do_step();
        check("q_valid1", 32'(spike_valid), 1);
        check("q_idx1", 32'(spike_idx), 0);
        check("q_no_ovr1", 32'(overrun), 0);
        do_step();
        check("q_ovr2", 32'(overrun), 1);
        spike_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            check("q_drain_valid", 32'(spike_valid), 1);
            check("q_drain_idx", 32'(spike_idx), 32'(k));
            tick();
        end
        spike_ready = 1'b0;
        check("q_empty", 32'(spike_valid), 0);

        // Step during sweep is dropped; exact done and update timing
        do_reset();
        write_cur(3, 50);
        mon_idx = 3;
        step = 1'b1;
        tick();                       // edge t sampled step
        step = 1'b0;
        check("t1_busy", 32'(busy), 1);
        check("t1_cur_ready", 32'(cur_ready), 0);
        check("t1_done", 32'(done), 0);
        tick();                       // cycle t+2
        step = 1'b1;
        tick();                       // edge t+2 sampled second step
        step = 1'b0;
        check("t3_overrun", 32'(overrun), 1);
        check("t3_done", 32'(done), 0);
        tick();                       // cycle t+4
        check("t4_done", 32'(done), 0);
        check("t4_n3_old", 32'(mon_state), 0);
        tick();                       // cycle t+5
        check("t5_done", 32'(done), 1);
        check("t5_cur_ready", 32'(cur_ready), 0);
        check("t5_n3_new", 32'(mon_state), 50);
        tick();                       // cycle t+6
        check("t6_done", 32'(done), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_cur_ready", 32'(cur_ready), 1);
        repeat (6) tick();
        check("t_single_sweep", 32'(mon_state), 50);
        check("t_ovr_sticky", 32'(overrun), 1);

        // Reset mid-sweep aborts immediately
        do_reset();
        for (int i = 0; i < N; i++) write_cur(2'(i), 10);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();                       // neurons 0 and 1 updated
        mon(0, 10, "rs_mid_n0");
        mon(2, 0, "rs_mid_n2");
        reset_n = 1'b0;
        #1;
        check("rs_busy", 32'(busy), 0);
        check("rs_done", 32'(done), 0);
        check("rs_cur_ready", 32'(cur_ready), 1);
        check("rs_spike_valid", 32'(spike_valid), 0);
        check("rs_overrun", 32'(overrun), 0);
        mon(0, 0, "rs_n0");
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("rs_no_resume", 32'(busy), 0);
        mon(2, 0, "rs_n2");
        mon(3, 0, "rs_n3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
